// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI receive framer: checksum seed, error codes and FSM states.
package spi_frame_pkg;

    localparam logic [7:0] CHK_SEED_DEFAULT = 8'hCC;

    localparam logic [1:0] ERR_CHECKSUM = 2'd0;
    localparam logic [1:0] ERR_LEN      = 2'd1;
    localparam logic [1:0] ERR_TRUNC    = 2'd2;
    localparam logic [1:0] ERR_BUSY     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN,
        ST_DISCARD
    } rx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_rx_framer.sv
// SPI mode-0 receive framer: deserializes cmd/len/payload/checksum frames and releases
// each frame as a byte stream only after its XOR checksum verifies.
module spi_rx_framer
    import spi_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CHK_SEED    = CHK_SEED_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] out_len,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk(clk_in), .rst_n(rst_n), .d(spi_clk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk_in), .rst_n(rst_n), .d(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk_in), .rst_n(rst_n), .d(spi_mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_level, sclk_fall, mosi_rise, mosi_fall};

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_done;
    logic [7:0] rx_byte;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            rx_byte   <= '0;
        end else begin
            byte_done <= 1'b0;
            if (cs_level) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], mosi_level};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {shreg, mosi_level};
                end
            end
        end
    end

    rx_state_t  state;
    logic [7:0] cmd_reg;
    logic [7:0] len_reg;
    logic [7:0] wr_idx;
    logic [7:0] rd_idx;
    logic [7:0] sum;
    logic       busy_ign;
    logic [7:0] frame_buf [MAX_LEN];

    always_ff @(posedge clk_in) begin
        if (state == ST_PAYLOAD && byte_done && !cs_rise) begin
            frame_buf[wr_idx[IDX_W-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_reg   <= '0;
            len_reg   <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            sum       <= '0;
            busy_ign  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_len   <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (cs_rise) begin
                busy_ign <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!cs_level && !busy_ign) begin
                        state <= ST_CMD;
                        sum   <= CHK_SEED;
                    end
                end

                ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK: begin
                    if (cs_rise) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TRUNC;
                        state     <= ST_IDLE;
                    end else if (byte_done) begin
                        case (state)
                            ST_CMD: begin
                                cmd_reg <= rx_byte;
                                sum     <= sum ^ rx_byte;
                                state   <= ST_LEN;
                            end
                            ST_LEN: begin
                                sum     <= sum ^ rx_byte;
                                len_reg <= rx_byte;
                                wr_idx  <= '0;
                                if (rx_byte > MAX_LEN_B) begin
                                    err_pulse <= 1'b1;
                                    err_code  <= ERR_LEN;
                                    state     <= ST_DISCARD;
                                end else if (rx_byte == 8'd0) begin
                                    state <= ST_CHK;
                                end else begin
                                    state <= ST_PAYLOAD;
                                end
                            end
                            ST_PAYLOAD: begin
                                sum    <= sum ^ rx_byte;
                                wr_idx <= wr_idx + 8'd1;
                                if (wr_idx == len_reg - 8'd1) begin
                                    state <= ST_CHK;
                                end
                            end
                            default: begin
                                if (rx_byte == sum) begin
                                    state     <= ST_DRAIN;
                                    out_valid <= 1'b1;
                                    out_data  <= cmd_reg;
                                    out_last  <= (len_reg == 8'd0);
                                    out_len   <= len_reg;
                                    rd_idx    <= '0;
                                end else begin
                                    err_pulse <= 1'b1;
                                    err_code  <= ERR_CHECKSUM;
                                    state     <= ST_DISCARD;
                                end
                            end
                        endcase
                    end
                end

                ST_DRAIN: begin
                    // A new frame starting now is dropped whole; the flag survives until its cs rise.
                    if (cs_fall) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_BUSY;
                        busy_ign  <= 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= cs_level ? ST_IDLE : ST_DISCARD;
                        end else begin
                            out_data <= frame_buf[rd_idx[IDX_W-1:0]];
                            out_last <= (rd_idx == out_len - 8'd1);
                            rd_idx   <= rd_idx + 8'd1;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (cs_level) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx_framer.sv
// Directed bench for spi_rx_framer: frame-level reference model plus per-cycle stream/error checks.
module tb_spi_rx_framer;

    localparam int MAX_LEN = 8;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } beat_t;

    logic       clk_in    = 1'b0;
    logic       rst_n     = 1'b0;
    logic       spi_clk   = 1'b0;
    logic       spi_cs_n  = 1'b1;
    logic       spi_mosi  = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] out_len;
    logic       err_pulse;
    logic [1:0] err_code;

    beat_t      exp_q[$];
    logic [1:0] err_q[$];
    logic [1:0] last_err = 2'd0;
    int         checks   = 0;
    int         errors   = 0;

    always #5 clk_in = ~clk_in;

    spi_rx_framer #(
        .MAX_LEN(MAX_LEN),
        .SYNC_STAGES(2),
        .CHK_SEED(8'hCC)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_len(out_len),
        .err_pulse(err_pulse), .err_code(err_code)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] chk_of(input bq_t q, input int count);
        logic [7:0] s = 8'hCC;
        for (int i = 0; i < count; i++) s = s ^ q[i];
        return s;
    endfunction

    // Frame-level model: what a host-transmitted byte sequence must produce.
    task automatic model_frame(input bq_t q, input int extra_bits);
        int n = q.size();
        int l;
        if (n == 0) begin
            if (extra_bits > 0) err_q.push_back(2'd2);
        end else if (n < 2) begin
            err_q.push_back(2'd2);
        end else begin
            l = int'(q[1]);
            if (l > MAX_LEN) begin
                err_q.push_back(2'd1);
            end else if (n < l + 3) begin
                err_q.push_back(2'd2);
            end else if (q[l+2] != chk_of(q, l + 2)) begin
                err_q.push_back(2'd0);
            end else begin
                exp_q.push_back(beat_t'{data: q[0], last: (l == 0), len: q[1]});
                for (int i = 0; i < l; i++)
                    exp_q.push_back(beat_t'{data: q[2+i], last: (i == l - 1), len: q[1]});
            end
        end
    endtask

    task automatic spi_send(input bq_t q, input int extra_bits, input logic [7:0] extra_val);
        logic [7:0] b;
        spi_cs_n = 1'b0;
        #100;
        for (int i = 0; i < q.size(); i++) begin
            b = q[i];
            for (int k = 7; k >= 0; k--) begin
                spi_mosi = b[k];
                #40 spi_clk = 1'b1;
                #40 spi_clk = 1'b0;
            end
        end
        for (int k = 0; k < extra_bits; k++) begin
            spi_mosi = extra_val[7-k];
            #40 spi_clk = 1'b1;
            #40 spi_clk = 1'b0;
        end
        #100 spi_cs_n = 1'b1;
        #300;
    endtask

    task automatic run_frame(input bq_t q, input int extra_bits, input logic [7:0] extra_val);
        model_frame(q, extra_bits);
        spi_send(q, extra_bits, extra_val);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk_in);
            if (exp_q.size() == 0 && err_q.size() == 0 && !out_valid) done = 1'b1;
        end
        chk({name, "_complete"}, 32'(done), 32'd1);
        repeat (20) @(negedge clk_in);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk_in);
            if (out_valid) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk_in);
        #2 out_ready = v;
    endtask

    logic  hold_pend = 1'b0;
    beat_t hold_b;

    always @(negedge clk_in) begin
        beat_t      e;
        logic [1:0] ec;
        if (!rst_n) begin
            hold_pend = 1'b0;
            last_err  = 2'd0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (!out_valid || beat_t'{data: out_data, last: out_last, len: out_len} != hold_b) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b %h/%0b/%0d want %h/%0b/%0d", out_valid,
                             out_data, out_last, out_len, hold_b.data, hold_b.last, hold_b.len);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h/%0b/%0d want none", out_data, out_last, out_len);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_last !== e.last || out_len !== e.len) begin
                        errors++;
                        $display("FAIL beat: got %h/%0b/%0d want %h/%0b/%0d",
                                 out_data, out_last, out_len, e.data, e.last, e.len);
                    end
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_b    = beat_t'{data: out_data, last: out_last, len: out_len};
            checks++;
            if (err_pulse) begin
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: got code %0d want no pulse", err_code);
                end else begin
                    ec       = err_q.pop_front();
                    last_err = ec;
                    if (err_code !== ec) begin
                        errors++;
                        $display("FAIL err_code: got %0d want %0d", err_code, ec);
                    end
                end
            end else if (err_code !== last_err) begin
                errors++;
                $display("FAIL err_hold: got %0d want %0d", err_code, last_err);
            end
        end
    end

    initial begin
        bq_t fa, fb, fbad, flen, ftrunc, fmax, freply;
        fa     = '{8'h01, 8'h02, 8'hAA, 8'h55, 8'h30};
        fb     = '{8'h10, 8'h00, 8'hDC};
        fbad   = '{8'h01, 8'h02, 8'hAA, 8'h55, 8'h31};
        flen   = '{8'h07, 8'h09, 8'h11, 8'h22, 8'h33};
        ftrunc = '{8'h01, 8'h02, 8'hAA};
        fmax   = '{8'h20, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hE4};
        freply = '{8'h01, 8'h02, 8'hAA, 8'h55, 8'h30, 8'h5A, 8'hA5};

        chk("model_chk_a",   32'(chk_of(fa, 4)),   32'h30);
        chk("model_chk_b",   32'(chk_of(fb, 2)),   32'hDC);
        chk("model_chk_max", 32'(chk_of(fmax, 10)), 32'hE4);

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_len",   32'(out_len),   32'd0);
        chk("rst_err_p", 32'(err_pulse), 32'd0);
        chk("rst_err_c", 32'(err_code),  32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk_in);

        run_frame(fa, 0, 8'h00);       wait_idle("frame_a");
        run_frame(fb, 0, 8'h00);       wait_idle("frame_len0");
        run_frame(fbad, 0, 8'h00);     wait_idle("bad_checksum");
        run_frame(flen, 0, 8'h00);     wait_idle("len_too_big");
        run_frame(ftrunc, 3, 8'hA0);   wait_idle("truncated");
        run_frame(fb, 0, 8'h00);       wait_idle("after_trunc");
        run_frame(fmax, 0, 8'h00);     wait_idle("len_max");
        run_frame(freply, 0, 8'h00);   wait_idle("trailing_reply");

        // Second frame arrives while the first is still held by backpressure.
        set_ready(1'b0);
        run_frame(fa, 0, 8'h00);
        wait_valid("busy_first_valid");
        err_q.push_back(2'd3);
        spi_send(fb, 0, 8'h00);
        repeat (50) @(negedge clk_in);
        chk("busy_still_valid", 32'(out_valid), 32'd1);
        chk("busy_held_cmd",    32'(out_data),  32'h01);
        set_ready(1'b1);
        wait_idle("busy_drain");

        // Reset during a stalled drain discards the frame.
        set_ready(1'b0);
        spi_send(fa, 0, 8'h00);
        wait_valid("rst_drain_valid");
        @(posedge clk_in);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_data",  32'(out_data),  32'd0);
        chk("rst_mid_len",   32'(out_len),   32'd0);
        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;
        set_ready(1'b1);
        repeat (20) @(negedge clk_in);
        chk("rst_no_output", 32'(out_valid), 32'd0);
        run_frame(fb, 0, 8'h00);       wait_idle("after_reset");

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("err_q_empty", 32'(err_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
